beep_arbiter: RTL

BEEP_ARBITER -- requirements
Module: beep_arbiter

---
 rtl/beep_arbiter_if.sv | 39 +++
 rtl/beep_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/beep_arbiter_if.sv
// Purpose: groups the buzzer arbiter request inputs and status outputs into one bundle.
// Latency: none; this is wiring only.
// Backpressure: none; requests are fire-and-forget pulses and the outputs are levels.
// Signals: key_req, vend_req (1-cycle pulses), music_en, music_tone, mute (levels) go
//          toward the arbiter; beep, grant[1:0], busy come back from it.
interface beep_arbiter_if;
  logic       key_req;
  logic       vend_req;
  logic       music_en;
  logic       music_tone;
  logic       mute;
  logic       beep;
  logic [1:0] grant;
  logic       busy;

  // Requester side: the keypad, vending controller and melody player.
  modport master (
    output key_req,
    output vend_req,
    output music_en,
    output music_tone,
    output mute,
    input  beep,
    input  grant,
    input  busy
  );

  // Arbiter side.
  modport slave (
    input  key_req,
    input  vend_req,
    input  music_en,
    input  music_tone,
    input  mute,
    output beep,
    output grant,
    output busy
  );
endinterface

// File: rtl/beep_arbiter.sv
// Purpose: fixed-priority buzzer arbiter (MUSIC > VEND > KEY) with key/alert tone generation.
// Latency: request sampled on an edge owns the buzzer from the next cycle; beep is registered-state driven.
// Backpressure: none; requests that lose arbitration or arrive during MUSIC are dropped, not queued.
// Ports: clk (only clock), rst_n (async active-low), bus (beep_arbiter_if.slave):
//        key_req/vend_req pulses, music_en/music_tone from the melody player, mute,
//        beep drive, grant (0 IDLE, 1 KEY, 2 VEND, 3 MUSIC), busy (grant != 0).
module beep_arbiter #(
  parameter int KEY_CYC   = 10_000_000,
  parameter int VEND_CYC  = 100_000_000,
  parameter int KEY_HALF  = 25_000,
  parameter int VEND_HALF = 12_500,
  parameter int GATE_CYC  = 12_500_000
) (
  input  logic          clk,
  input  logic          rst_n,
  beep_arbiter_if.slave bus
);

  localparam int MAX_CYC  = (KEY_CYC > VEND_CYC) ? KEY_CYC : VEND_CYC;
  localparam int MAX_HALF = (KEY_HALF > VEND_HALF) ? KEY_HALF : VEND_HALF;
  localparam int TW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int HW = (MAX_HALF > 1) ? $clog2(MAX_HALF) : 1;
  localparam int GW = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;

  // Timer counts down to zero; loading N-1 makes the state last exactly N cycles.
  localparam logic [TW-1:0] KEY_LOAD  = TW'(KEY_CYC - 1);
  localparam logic [TW-1:0] VEND_LOAD = TW'(VEND_CYC - 1);
  localparam logic [HW-1:0] KEY_HLAST  = HW'(KEY_HALF - 1);
  localparam logic [HW-1:0] VEND_HLAST = HW'(VEND_HALF - 1);
  localparam logic [GW-1:0] GATE_LAST  = GW'(GATE_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_KEY   = 2'd1,
    S_VEND  = 2'd2,
    S_MUSIC = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          load;        // entry into, or restart of, KEY/VEND
  logic [TW-1:0] timer_q;
  logic [HW-1:0] half_q;
  logic          phase_q;
  logic [GW-1:0] gate_cnt_q;
  logic          gate_q;
  logic [HW-1:0] half_last;
  logic          beep_c;

  // Next state and restart decision.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.music_en) begin
          state_d = S_MUSIC;
        end else if (bus.vend_req) begin
          state_d = S_VEND;
          load    = 1'b1;
        end else if (bus.key_req) begin
          state_d = S_KEY;
          load    = 1'b1;
        end
      end
      S_KEY: begin
        if (bus.music_en) begin
          state_d = S_MUSIC;
        end else if (bus.vend_req) begin
          state_d = S_VEND;
          load    = 1'b1;
        end else if (bus.key_req) begin
          load    = 1'b1;
        end else if (timer_q == '0) begin
          state_d = S_IDLE;
        end
      end
      S_VEND: begin
        // key_req is deliberately ignored here.
        if (bus.music_en) begin
          state_d = S_MUSIC;
        end else if (bus.vend_req) begin
          load    = 1'b1;
        end else if (timer_q == '0) begin
          state_d = S_IDLE;
        end
      end
      S_MUSIC: begin
        if (!bus.music_en) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign half_last = (state_q == S_KEY) ? KEY_HLAST : VEND_HLAST;

  // State register plus duration timer, tone phase and alert gate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      half_q     <= '0;
      phase_q    <= 1'b0;
      gate_cnt_q <= '0;
      gate_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        timer_q    <= (state_d == S_KEY) ? KEY_LOAD : VEND_LOAD;
        half_q     <= '0;
        phase_q    <= 1'b1;
        gate_cnt_q <= '0;
        gate_q     <= 1'b1;
      end else if (state_d == S_KEY || state_d == S_VEND) begin
        // Only reachable while staying in the same sounding state, so timer_q is non-zero.
        if (timer_q != '0) begin
          timer_q <= timer_q - TW'(1);
        end
        if (half_q == half_last) begin
          half_q  <= '0;
          phase_q <= ~phase_q;
        end else begin
          half_q  <= half_q + HW'(1);
        end
        if (gate_cnt_q == GATE_LAST) begin
          gate_cnt_q <= '0;
          gate_q     <= ~gate_q;
        end else begin
          gate_cnt_q <= gate_cnt_q + GW'(1);
        end
      end else begin
        // Leaving for IDLE/MUSIC discards the sound so it cannot resume later.
        timer_q    <= '0;
        half_q     <= '0;
        phase_q    <= 1'b0;
        gate_cnt_q <= '0;
        gate_q     <= 1'b0;
      end
    end
  end

  // Output mux driven only by registers (plus the mute/music_tone levels), so no
  // decode glitch appears on state changes.
  always_comb begin
    beep_c = 1'b0;
    if (!bus.mute) begin
      case (state_q)
        S_KEY:   beep_c = phase_q;
        S_VEND:  beep_c = phase_q & gate_q;
        S_MUSIC: beep_c = bus.music_tone;
        default: beep_c = 1'b0;
      endcase
    end
  end

  assign bus.beep  = beep_c;
  assign bus.grant = state_q;
  assign bus.busy  = (state_q != S_IDLE);

endmodule
